inst_fetch: RTL and testbench

- Instruction-fetch stage of the RISC-V core, directly upstream of immediate generation and decode.
- Owns the PC and issues word fetches to instruction memory over a req/ack handshake.
- Presents one fetched instruction plus its PC to decode, holding it while decode stalls.
- Accepts branch/jump redirects from execute and flushes any wrong-path fetch.

---
 rtl/inst_fetch.sv | 166 ++++++++++++++++
 tb/tb_inst_fetch.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//   Instruction-fetch stage. Owns the PC, issues one word fetch at a time to
//   instruction memory over a req/ack handshake, and presents the fetched
//   instruction plus its PC to decode, holding it while decode stalls.
//   Redirects from execute replace the PC and flush any wrong-path fetch.
//   A redirect to a non-word-aligned PC raises a sticky error and halts the
//   stage until reset. A request that is still waiting for its ack when a
//   redirect arrives is completed first and its data is thrown away.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   o_imem_req            fetch request to instruction memory
//   o_imem_addr           fetch byte address (held stable until ack)
//   i_imem_ack            memory accepted request; i_imem_rdata valid now
//   i_imem_rdata          fetched instruction word
//   i_redirect_valid      execute requests a PC change
//   i_redirect_pc         target PC for the redirect
//   i_stall               decode cannot consume o_if_inst this cycle
//   o_if_valid            o_if_inst / o_if_pc hold a valid instruction
//   o_if_inst             instruction to decode (NOP_INST when not valid)
//   o_if_pc               PC of o_if_inst
//   o_misalign_err        sticky: redirect to a non-word-aligned PC
// ---------------------------------------------------------------------------
module inst_fetch #(
   parameter int               XLEN     = 64,
   parameter logic [XLEN-1:0]  RESET_PC = '0,
   parameter logic [31:0]      NOP_INST = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            o_imem_req,
   output logic [XLEN-1:0] o_imem_addr,
   input  logic            i_imem_ack,
   input  logic [31:0]     i_imem_rdata,
   input  logic            i_redirect_valid,
   input  logic [XLEN-1:0] i_redirect_pc,
   input  logic            i_stall,
   output logic            o_if_valid,
   output logic [31:0]     o_if_inst,
   output logic [XLEN-1:0] o_if_pc,
   output logic            o_misalign_err
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_OUT   = 3'd2,
      S_DRAIN = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_drain_addr;
   logic            r_if_valid;
   logic [31:0]     r_if_inst;
   logic [XLEN-1:0] r_if_pc;
   logic            r_misalign_err;
   logic            r_halt_pend;   // misaligned redirect seen while draining

   // HALT ignores redirects entirely; everywhere else they take priority.
   logic w_redir;
   logic w_redir_mis;
   logic w_redir_ok;

   assign w_redir     = i_redirect_valid && (r_state != S_HALT);
   assign w_redir_mis = w_redir && (i_redirect_pc[1:0] != 2'b00);
   assign w_redir_ok  = w_redir && (i_redirect_pc[1:0] == 2'b00);

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            w_next = w_redir_mis ? S_HALT : S_REQ;
         end
         S_REQ: begin
            // An unacked request cannot be withdrawn, so a redirect without
            // ack goes through DRAIN to finish it.
            if (w_redir_mis)     w_next = i_imem_ack ? S_HALT : S_DRAIN;
            else if (w_redir_ok) w_next = i_imem_ack ? S_REQ  : S_DRAIN;
            else if (i_imem_ack) w_next = S_OUT;
         end
         S_OUT: begin
            if (w_redir_mis)     w_next = S_HALT;
            else if (w_redir_ok) w_next = S_REQ;
            else if (!i_stall)   w_next = S_REQ;
         end
         S_DRAIN: begin
            if (i_imem_ack)
               w_next = (r_halt_pend || w_redir_mis) ? S_HALT : S_REQ;
         end
         S_HALT: begin
            w_next = S_HALT;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------ outputs
   always_comb begin
      o_imem_req  = (r_state == S_REQ) || (r_state == S_DRAIN);
      o_imem_addr = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
   end

   // ----------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc           <= RESET_PC;
         r_drain_addr   <= RESET_PC;
         r_if_valid     <= 1'b0;
         r_if_inst      <= NOP_INST;
         r_if_pc        <= '0;
         r_misalign_err <= 1'b0;
         r_halt_pend    <= 1'b0;
      end else if (w_redir) begin
         // Any redirect flushes whatever decode is looking at.
         r_if_valid <= 1'b0;
         r_if_inst  <= NOP_INST;
         if (w_redir_mis) begin
            r_misalign_err <= 1'b1;
            r_halt_pend    <= 1'b1;
         end else begin
            r_pc <= i_redirect_pc;
         end
         // Remember the in-flight address so it stays on the bus until ack.
         if ((r_state == S_REQ) && !i_imem_ack)
            r_drain_addr <= r_pc;
      end else begin
         case (r_state)
            S_REQ: begin
               if (i_imem_ack) begin
                  r_if_valid <= 1'b1;
                  r_if_inst  <= i_imem_rdata;
                  r_if_pc    <= r_pc;
                  r_pc       <= r_pc + XLEN'(4);
               end
            end
            S_OUT: begin
               if (!i_stall) begin
                  r_if_valid <= 1'b0;
                  r_if_inst  <= NOP_INST;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign o_if_valid     = r_if_valid;
   assign o_if_inst      = r_if_inst;
   assign o_if_pc        = r_if_pc;
   assign o_misalign_err = r_misalign_err;

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch
//   Directed bench for inst_fetch. The stimulus thread plays the role of
//   instruction memory and execute; whenever it hands out an ack it queues
//   the address that must be on the bus and the (pc, inst) pair that must
//   later appear on the decode interface. Two monitors pop and compare those
//   queues independently of the stimulus.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

   localparam int          XLEN = 64;
   localparam logic [31:0] NOP  = 32'h0000_0013;

   logic            clk;
   logic            rst_n;
   logic            o_imem_req;
   logic [XLEN-1:0] o_imem_addr;
   logic            i_imem_ack;
   logic [31:0]     i_imem_rdata;
   logic            i_redirect_valid;
   logic [XLEN-1:0] i_redirect_pc;
   logic            i_stall;
   logic            o_if_valid;
   logic [31:0]     o_if_inst;
   logic [XLEN-1:0] o_if_pc;
   logic            o_misalign_err;

   int n_chk = 0;
   int n_err = 0;

   logic [XLEN-1:0] addr_q[$];
   logic [XLEN-1:0] pc_q[$];
   logic [31:0]     inst_q[$];

   inst_fetch #(.XLEN(XLEN), .RESET_PC('0), .NOP_INST(NOP)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .o_imem_req       (o_imem_req),
      .o_imem_addr      (o_imem_addr),
      .i_imem_ack       (i_imem_ack),
      .i_imem_rdata     (i_imem_rdata),
      .i_redirect_valid (i_redirect_valid),
      .i_redirect_pc    (i_redirect_pc),
      .i_stall          (i_stall),
      .o_if_valid       (o_if_valid),
      .o_if_inst        (o_if_inst),
      .o_if_pc          (o_if_pc),
      .o_misalign_err   (o_misalign_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Caller is in a REQ cycle for address a; memory waits 'waits' cycles.
   task automatic fetch(input logic [XLEN-1:0] a, input logic [31:0] d, input int waits);
      for (int w = 0; w < waits; w++) begin
         i_imem_ack = 1'b0;
         chk("req_held", o_imem_req, 1);
         chk("addr_held", o_imem_addr, a);
         chk("valid_low_wait", o_if_valid, 0);
         tick();
      end
      chk("req", o_imem_req, 1);
      chk("addr", o_imem_addr, a);
      i_imem_ack   = 1'b1;
      i_imem_rdata = d;
      addr_q.push_back(a);
      pc_q.push_back(a);
      inst_q.push_back(d);
      tick();
      i_imem_ack   = 1'b0;
      i_imem_rdata = 32'hDEAD_BEEF;
      chk("valid_after_ack", o_if_valid, 1);
   endtask

   // Ends in the first REQ cycle after reset release.
   task automatic do_reset();
      i_imem_ack       = 1'b0;
      i_imem_rdata     = 32'h0;
      i_redirect_valid = 1'b0;
      i_redirect_pc    = '0;
      i_stall          = 1'b0;
      rst_n            = 1'b0;
      tick();
      tick();
      chk("rst_req", o_imem_req, 0);
      chk("rst_addr", o_imem_addr, 0);
      chk("rst_valid", o_if_valid, 0);
      chk("rst_inst", o_if_inst, NOP);
      chk("rst_pc", o_if_pc, 0);
      chk("rst_err", o_misalign_err, 0);
      rst_n = 1'b1;
      i_imem_ack = 1'b1;          // ack with no request must be ignored
      chk("idle_req", o_imem_req, 0);
      tick();
      i_imem_ack = 1'b0;
      chk("first_req", o_imem_req, 1);
      chk("first_addr", o_imem_addr, 0);
   endtask

   // Address monitor: every accepted handshake must carry the queued address.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && o_imem_req && i_imem_ack) begin
            if (addr_q.size() == 0) begin
               chk("unexpected_ack_addr", o_imem_addr, '1);
            end else begin
               chk("mon_imem_addr", o_imem_addr, addr_q.pop_front());
            end
         end
      end
   end

   // Decode-side monitor: each new valid instruction must match the queue.
   initial begin
      bit prev_v;
      prev_v = 1'b0;
      forever begin
         @(negedge clk);
         if (o_if_valid && !prev_v) begin
            if (pc_q.size() == 0) begin
               chk("unexpected_if_valid", o_if_pc, '1);
            end else begin
               chk("mon_if_pc", o_if_pc, pc_q.pop_front());
               chk("mon_if_inst", {32'h0, o_if_inst}, {32'h0, inst_q.pop_front()});
            end
         end
         prev_v = o_if_valid;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      do_reset();

      // Memory with 3 wait cycles, then hold the result under stall.
      fetch(64'h0, 32'h00A0_0093, 3);
      i_stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("stall_inst", o_if_inst, 32'h00A0_0093);
         chk("stall_pc", o_if_pc, 0);
         chk("stall_valid", o_if_valid, 1);
         chk("stall_req", o_imem_req, 0);
         tick();
      end
      i_stall = 1'b0;
      tick();
      chk("post_stall_req", o_imem_req, 1);
      chk("post_stall_addr", o_imem_addr, 64'h4);
      chk("post_stall_valid", o_if_valid, 0);

      // Redirect in OUT beats stall.
      fetch(64'h4, 32'h0010_8113, 0);
      i_stall          = 1'b1;
      i_redirect_valid = 1'b1;
      i_redirect_pc    = 64'h100;
      tick();
      i_redirect_valid = 1'b0;
      i_stall          = 1'b0;
      chk("redir_out_valid", o_if_valid, 0);
      chk("redir_out_inst", o_if_inst, NOP);
      chk("redir_out_addr", o_imem_addr, 64'h100);
      fetch(64'h100, 32'h0000_0513, 0);
      tick();
      chk("seq_addr_104", o_imem_addr, 64'h104);

      // Redirect with same-cycle ack: data dropped, new address next cycle.
      i_imem_ack       = 1'b1;
      i_imem_rdata     = 32'hBAD0_0BAD;
      i_redirect_valid = 1'b1;
      i_redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
      addr_q.push_back(64'h104);
      tick();
      i_imem_ack       = 1'b0;
      i_redirect_valid = 1'b0;
      chk("redir_ack_valid", o_if_valid, 0);
      chk("redir_ack_addr", o_imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      fetch(64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0073, 0);
      tick();
      chk("pc_wrap_addr", o_imem_addr, 64'h0);

      // Zero-wait sequence 0x0, 0x4, 0x8 then redirect while waiting on 0x8.
      do_reset();
      fetch(64'h0, 32'h00A0_0093, 0);
      tick();
      chk("valid_pulse", o_if_valid, 0);
      fetch(64'h4, 32'h0010_8113, 0);
      tick();
      chk("seq_addr_8", o_imem_addr, 64'h8);
      i_redirect_valid = 1'b1;
      i_redirect_pc    = 64'h200;
      tick();
      i_redirect_valid = 1'b0;
      chk("drain_req", o_imem_req, 1);
      chk("drain_addr", o_imem_addr, 64'h8);
      tick();
      chk("drain_addr2", o_imem_addr, 64'h8);
      chk("drain_valid", o_if_valid, 0);
      i_imem_ack   = 1'b1;
      i_imem_rdata = 32'hDEAD_BEEF;
      addr_q.push_back(64'h8);
      tick();
      i_imem_ack = 1'b0;
      chk("after_drain_addr", o_imem_addr, 64'h200);
      chk("after_drain_valid", o_if_valid, 0);
      fetch(64'h200, 32'h0000_0297, 0);
      tick();

      // Misaligned redirect from OUT: sticky error, halted, redirects ignored.
      fetch(64'h204, 32'h0002_8067, 0);
      i_redirect_valid = 1'b1;
      i_redirect_pc    = 64'h102;
      tick();
      chk("mis_err", o_misalign_err, 1);
      chk("mis_valid", o_if_valid, 0);
      chk("mis_inst", o_if_inst, NOP);
      chk("mis_req", o_imem_req, 0);
      i_redirect_pc = 64'h300;
      i_imem_ack    = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("halt_req", o_imem_req, 0);
         chk("halt_err", o_misalign_err, 1);
         chk("halt_valid", o_if_valid, 0);
      end

      // Reset clears halt; misaligned redirect while waiting drains first.
      do_reset();
      i_redirect_valid = 1'b1;
      i_redirect_pc    = 64'h3;
      tick();
      i_redirect_valid = 1'b0;
      chk("mis_drain_err", o_misalign_err, 1);
      chk("mis_drain_req", o_imem_req, 1);
      chk("mis_drain_addr", o_imem_addr, 64'h0);
      i_imem_ack = 1'b1;
      addr_q.push_back(64'h0);
      tick();
      i_imem_ack = 1'b0;
      chk("mis_drain_halt", o_imem_req, 0);
      tick();
      chk("mis_drain_halt2", o_imem_req, 0);
      chk("mis_drain_valid", o_if_valid, 0);

      tick();
      chk("addr_q_empty", addr_q.size(), 0);
      chk("if_q_empty", pc_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
